// File: rtl/inv_shift_rows_serial_pkg.sv
// Shared constants and index maps for the serial (Inv)ShiftRows block.
// The state is column-major: byte index i = r + 4c, r = i[1:0], c = i[3:2].
package aes_isr_pkg;

  localparam int NB = 16;

  typedef logic [3:0] idx_t;

  // Output position r+4c reads input position r + 4*((c - r) mod 4).
  // The 2-bit column arithmetic wraps modulo 4 for free.
  function automatic idx_t inv_map(idx_t i);
    logic [1:0] r, c, cs;
    r  = i[1:0];
    c  = i[3:2];
    cs = c - r;
    return {cs, r};
  endfunction

  // Forward ShiftRows: output position r+4c reads r + 4*((c + r) mod 4).
  function automatic idx_t fwd_map(idx_t i);
    logic [1:0] r, c, cs;
    r  = i[1:0];
    c  = i[3:2];
    cs = c + r;
    return {cs, r};
  endfunction

endpackage

// File: rtl/inv_shift_rows_serial_if.sv
// Byte-stream bus for inv_shift_rows_serial: one input stream, one output stream.
// Optional macro ISR_FWD_MODE_EN adds the per-block fwd select bit.
interface inv_shift_rows_serial_if #(parameter int BYTE_W = 8);
  logic [BYTE_W-1:0] in_byte;
  logic              in_valid;
  logic              in_ready;
  logic [BYTE_W-1:0] out_byte;
  logic              out_valid;
  logic              out_ready;
  logic              out_last;
`ifdef ISR_FWD_MODE_EN
  logic              fwd;

  modport master (output in_byte, in_valid, out_ready, fwd,
                  input  in_ready, out_byte, out_valid, out_last);
  modport slave  (input  in_byte, in_valid, out_ready, fwd,
                  output in_ready, out_byte, out_valid, out_last);
`else
  modport master (output in_byte, in_valid, out_ready,
                  input  in_ready, out_byte, out_valid, out_last);
  modport slave  (input  in_byte, in_valid, out_ready,
                  output in_ready, out_byte, out_valid, out_last);
`endif
endinterface

// File: rtl/inv_shift_rows_serial_bank.sv
// isr_bank: 16 x BYTE_W register file, one write port, one combinational
// read port, asynchronously cleared to zero.
module isr_bank
  import aes_isr_pkg::*;
#(
  parameter int BYTE_W = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              we,
  input  idx_t              waddr,
  input  logic [BYTE_W-1:0] wdata,
  input  idx_t              raddr,
  output logic [BYTE_W-1:0] rdata
);

  logic [NB-1:0][BYTE_W-1:0] mem;

  // Byte write; reset clears the whole bank so a reset leaves out_byte at 0.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     mem        <= '0;
    else if (we) mem[waddr] <= wdata;
  end

  // Unregistered read so the reorder costs no latency.
  always_comb rdata = mem[raddr];

endmodule

// File: rtl/inv_shift_rows_serial.sv
// inv_shift_rows_serial: byte-serial InvShiftRows using two ping-pong banks.
// Input bytes are written in arrival order; the reorder is applied on read
// via the index map, so one bank fills while the other drains.
// Optional macro ISR_FWD_MODE_EN: per-block fwd bit selects forward ShiftRows.
module inv_shift_rows_serial
  import aes_isr_pkg::*;
#(
  parameter int BYTE_W = 8
) (
  input  logic                  clk,
  input  logic                  rst,
  inv_shift_rows_serial_if.slave s
);

  logic [1:0]             full;
  logic                   wr_sel, rd_sel;
  idx_t                   wr_cnt, rd_cnt;
  idx_t                   raddr;
  logic [1:0][BYTE_W-1:0] rdata;
  logic                   in_rdy, out_vld;
  logic                   wr_fire, rd_fire;
`ifdef ISR_FWD_MODE_EN
  logic [1:0]             fwd_q;
`endif

  // Handshake decodes come only from registered state.
  always_comb begin
    in_rdy  = ~full[wr_sel];
    out_vld = full[rd_sel];
    wr_fire = s.in_valid & in_rdy;
    rd_fire = s.out_ready & out_vld;
  end

  // Read address: reorder map for the bank being drained.
  always_comb begin
`ifdef ISR_FWD_MODE_EN
    raddr = fwd_q[rd_sel] ? fwd_map(rd_cnt) : inv_map(rd_cnt);
`else
    raddr = inv_map(rd_cnt);
`endif
  end

  // Bank pair; only the bank selected for writing sees the write enable.
  for (genvar b = 0; b < 2; b++) begin : g_bank
    isr_bank #(.BYTE_W(BYTE_W)) u_bank (
      .clk   (clk),
      .rst   (rst),
      .we    (wr_fire && (wr_sel == 1'(b))),
      .waddr (wr_cnt),
      .wdata (s.in_byte),
      .raddr (raddr),
      .rdata (rdata[b])
    );
  end

  // Fill/drain bookkeeping. A filling bank is never full and a draining bank
  // always is, so the two full-flag updates never touch the same bit.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full   <= '0;
      wr_sel <= 1'b0;
      rd_sel <= 1'b0;
      wr_cnt <= '0;
      rd_cnt <= '0;
`ifdef ISR_FWD_MODE_EN
      fwd_q  <= '0;
`endif
    end else begin
      if (wr_fire) begin
        wr_cnt <= wr_cnt + 4'd1;
`ifdef ISR_FWD_MODE_EN
        if (wr_cnt == 4'd0) fwd_q[wr_sel] <= s.fwd;
`endif
        if (wr_cnt == 4'hF) begin
          full[wr_sel] <= 1'b1;
          wr_sel       <= ~wr_sel;
        end
      end
      if (rd_fire) begin
        rd_cnt <= rd_cnt + 4'd1;
        if (rd_cnt == 4'hF) begin
          full[rd_sel] <= 1'b0;
          rd_sel       <= ~rd_sel;
        end
      end
    end
  end

  // Output decodes.
  always_comb begin
    s.in_ready  = in_rdy;
    s.out_valid = out_vld;
    s.out_byte  = rdata[rd_sel];
    s.out_last  = out_vld & (rd_cnt == 4'hF);
  end

endmodule

// File: tb/tb_inv_shift_rows_serial.sv
// Directed bench for inv_shift_rows_serial. A byte-level model rebuilds each
// block from accepted inputs and the (Inv)ShiftRows row-rotation rule; a
// negedge monitor compares every valid output against it.
module tb_inv_shift_rows_serial;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks   = 0;
  int   failures = 0;
  int   cyc      = 0;

  always #5 clk = ~clk;

  inv_shift_rows_serial_if #(.BYTE_W(8)) bus ();

  inv_shift_rows_serial #(.BYTE_W(8)) dut (
    .clk (clk),
    .rst (rst),
    .s   (bus)
  );

  // Model state
  logic [7:0] part[$];
  logic       part_fwd;
  logic [7:0] exp_q[$];
  logic       exp_l[$];
  logic [7:0] obs[$];
  logic       obs_last[$];
  int         obs_cyc[$];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Output byte at (row r, column c) comes from input row r rotated by r columns.
  function automatic int src_idx(int i, bit f);
    int r, c;
    r = i % 4;
    c = i / 4;
    if (f) return r + 4 * ((c + r) % 4);
    return r + 4 * ((c - r + 4) % 4);
  endfunction

  // Monitor and model
  always @(negedge clk) begin
    cyc++;
    if (rst) begin
      part.delete();
      exp_q.delete();
      exp_l.delete();
    end else begin
      if (bus.out_valid) begin
        if (exp_q.size() == 0) begin
          chk("unexpected_out_valid", 32'(bus.out_valid), 32'd0);
        end else begin
          chk("out_byte", 32'(bus.out_byte), 32'(exp_q[0]));
          chk("out_last", 32'(bus.out_last), 32'(exp_l[0]));
          if (bus.out_ready) begin
            obs.push_back(bus.out_byte);
            obs_last.push_back(bus.out_last);
            obs_cyc.push_back(cyc);
            void'(exp_q.pop_front());
            void'(exp_l.pop_front());
          end
        end
      end else begin
        chk("out_last_idle", 32'(bus.out_last), 32'd0);
      end
      if (bus.in_valid && bus.in_ready) begin
`ifdef ISR_FWD_MODE_EN
        if (part.size() == 0) part_fwd = bus.fwd;
`else
        if (part.size() == 0) part_fwd = 1'b0;
`endif
        part.push_back(bus.in_byte);
        if (part.size() == 16) begin
          for (int i = 0; i < 16; i++) begin
            exp_q.push_back(part[src_idx(i, part_fwd)]);
            exp_l.push_back(i == 15);
          end
          part.delete();
        end
      end
    end
  end

  task automatic send_byte(input logic [7:0] b, input logic f);
    bit done;
    done = 1'b0;
    bus.in_byte  = b;
    bus.in_valid = 1'b1;
`ifdef ISR_FWD_MODE_EN
    bus.fwd = f;
`else
    if (f) $display("note: fwd ignored in inverse-only build");
`endif
    for (int k = 0; k < 50 && !done; k++) begin
      @(negedge clk);
      if (bus.in_ready) done = 1'b1;
    end
    if (!done) begin
      failures++;
      $display("FAIL send_timeout: byte %0h never accepted", b);
    end
    @(posedge clk);
    #1;
  endtask

  task automatic send_block(input logic [7:0] base, input logic f);
    for (int i = 0; i < 16; i++) send_byte(base + 8'(i), f);
  endtask

  task automatic idle_in();
    bus.in_valid = 1'b0;
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    for (int k = 0; k < 300 && !done; k++) begin
      @(negedge clk);
      if (exp_q.size() == 0 && !bus.out_valid) done = 1'b1;
    end
    if (!done) begin
      failures++;
      $display("FAIL drain_timeout: %0d bytes still expected", exp_q.size());
    end
    @(posedge clk);
    #1;
  endtask

  task automatic clear_obs();
    obs.delete();
    obs_last.delete();
    obs_cyc.delete();
  endtask

  logic [7:0] lit_inv[16] = '{8'h00, 8'h0D, 8'h0A, 8'h07, 8'h04, 8'h01, 8'h0E, 8'h0B,
                              8'h08, 8'h05, 8'h02, 8'h0F, 8'h0C, 8'h09, 8'h06, 8'h03};
  // FIPS-197 C.1 decryption round 1: istart, and the state after InvSubBytes.
  logic [7:0] fips_in[16]  = '{8'h7a, 8'hd5, 8'hfd, 8'ha7, 8'h89, 8'hef, 8'h4e, 8'h27,
                               8'h2b, 8'hca, 8'h10, 8'h0b, 8'h3d, 8'h9f, 8'hf5, 8'h9f};
  logic [7:0] fips_box[16] = '{8'hbd, 8'h6e, 8'h7c, 8'h3d, 8'hf2, 8'hb5, 8'h77, 8'h9e,
                               8'h0b, 8'h61, 8'h21, 8'h6e, 8'h8b, 8'h10, 8'hb6, 8'h89};

  // InvSubBytes restricted to the bytes this vector needs; anything else maps
  // to a poison value so a misordered byte cannot match.
  function automatic logic [8:0] inv_sbox_part(input logic [7:0] x);
    case (x)
      8'h7a: return 9'h0bd;  8'h9f: return 9'h06e;  8'h10: return 9'h07c;
      8'h27: return 9'h03d;  8'h89: return 9'h0f2;  8'hd5: return 9'h0b5;
      8'hf5: return 9'h077;  8'h0b: return 9'h09e;  8'h2b: return 9'h00b;
      8'hef: return 9'h061;  8'hfd: return 9'h021;  8'h3d: return 9'h08b;
      8'hca: return 9'h010;  8'h4e: return 9'h0b6;  8'ha7: return 9'h089;
      default: return 9'h100;
    endcase
  endfunction

  initial begin
    int acc;
    bit got, moved;
    bus.in_byte   = '0;
    bus.in_valid  = 1'b0;
    bus.out_ready = 1'b0;
`ifdef ISR_FWD_MODE_EN
    bus.fwd = 1'b0;
`endif
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("rst_out_last",  32'(bus.out_last),  32'd0);
    chk("rst_out_byte",  32'(bus.out_byte),  32'd0);
    rst = 1'b0;
    @(posedge clk);
    #1;

    // Single block; first output must appear the cycle after the 16th input.
    bus.out_ready = 1'b1;
    clear_obs();
    send_block(8'h00, 1'b0);
    idle_in();
    chk("latency_out_valid", 32'(bus.out_valid), 32'd1);
    drain();
    chk("single_count", 32'(obs.size()), 32'd16);
    if (obs.size() == 16) begin
      for (int i = 0; i < 16; i++) begin
        chk($sformatf("single_lit[%0d]", i), 32'(obs[i]), 32'(lit_inv[i]));
        chk($sformatf("single_last[%0d]", i), 32'(obs_last[i]), 32'(i == 15));
      end
    end

    // Back-to-back blocks, no idle output cycle between them.
    clear_obs();
    send_block(8'h00, 1'b0);
    send_block(8'h10, 1'b0);
    idle_in();
    drain();
    chk("b2b_count", 32'(obs.size()), 32'd32);
    if (obs.size() == 32) begin
      chk("b2b_no_gap", 32'(obs_cyc[31] - obs_cyc[0]), 32'd31);
      for (int i = 0; i < 16; i++)
        chk($sformatf("b2b_plus10[%0d]", i), 32'(obs[16 + i]), 32'(lit_inv[i] + 8'h10));
    end

    // Backpressure: three blocks offered, downstream stalled.
    bus.out_ready = 1'b0;
    clear_obs();
    acc   = 0;
    moved = 1'b0;
    for (int i = 0; i < 48; i++) begin
      bus.in_byte  = 8'(i);
      bus.in_valid = 1'b1;
      got = 1'b0;
      for (int k = 0; k < 4 && !got; k++) begin
        @(negedge clk);
        if (bus.out_byte != 8'h00) moved = 1'b1;
        if (bus.in_ready) got = 1'b1;
      end
      @(posedge clk);
      #1;
      if (got) acc++;
      else break;
    end
    chk("bp_accepted",  32'(acc), 32'd32);
    chk("bp_in_ready",  32'(bus.in_ready), 32'd0);
    chk("bp_out_valid", 32'(bus.out_valid), 32'd1);
    chk("bp_out_byte",  32'(bus.out_byte), 32'd0);
    chk("bp_byte_held", 32'(moved), 32'd0);
    idle_in();
    bus.out_ready = 1'b1;
    drain();
    chk("bp_drained", 32'(obs.size()), 32'd32);

    // Reset mid-block with one full bank waiting.
    bus.out_ready = 1'b0;
    send_block(8'h40, 1'b0);
    for (int i = 0; i < 7; i++) send_byte(8'h60 + 8'(i), 1'b0);
    idle_in();
    chk("pre_rst_out_valid", 32'(bus.out_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk("mid_rst_out_valid", 32'(bus.out_valid), 32'd0);
    chk("mid_rst_in_ready",  32'(bus.in_ready),  32'd1);
    chk("mid_rst_out_byte",  32'(bus.out_byte),  32'd0);
    @(negedge clk);
    @(posedge clk);
    #1;
    rst = 1'b0;
    bus.out_ready = 1'b1;
    clear_obs();
    send_block(8'h00, 1'b0);
    idle_in();
    drain();
    chk("post_rst_count", 32'(obs.size()), 32'd16);
    if (obs.size() == 16)
      for (int i = 0; i < 16; i++)
        chk($sformatf("post_rst_lit[%0d]", i), 32'(obs[i]), 32'(lit_inv[i]));

    // FIPS-197 round-1 decryption state through InvShiftRows then InvSubBytes.
    clear_obs();
    for (int i = 0; i < 16; i++) send_byte(fips_in[i], 1'b0);
    idle_in();
    drain();
    chk("fips_count", 32'(obs.size()), 32'd16);
    if (obs.size() == 16)
      for (int i = 0; i < 16; i++)
        chk($sformatf("fips_isb[%0d]", i), 32'(inv_sbox_part(obs[i])), 32'(fips_box[i]));

`ifdef ISR_FWD_MODE_EN
    // Forward block followed directly by an inverse block.
    begin
      logic [7:0] lit_fwd[16] = '{8'h00, 8'h05, 8'h0A, 8'h0F, 8'h04, 8'h09, 8'h0E, 8'h03,
                                  8'h08, 8'h0D, 8'h02, 8'h07, 8'h0C, 8'h01, 8'h06, 8'h0B};
      clear_obs();
      send_block(8'h00, 1'b1);
      send_block(8'h00, 1'b0);
      idle_in();
      drain();
      chk("fwd_count", 32'(obs.size()), 32'd32);
      if (obs.size() == 32)
        for (int i = 0; i < 16; i++) begin
          chk($sformatf("fwd_lit[%0d]", i), 32'(obs[i]), 32'(lit_fwd[i]));
          chk($sformatf("fwd_then_inv[%0d]", i), 32'(obs[16 + i]), 32'(lit_inv[i]));
        end
    end
`endif

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Global watchdog.
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule

// File: doc/inv_shift_rows_serial.md
INV_SHIFT_ROWS_SERIAL -- requirements
Module: inv_shift_rows_serial

Interface
REQ-001 Parameter BYTE_W, default 8: width of every data byte; only 8 is supported.
REQ-002 clk  input  1  single clock; all state updates on its rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 in_byte  input  BYTE_W  state byte, column-major order (index i = r + 4c).
REQ-005 in_valid  input  1  in_byte is valid this cycle.
REQ-006 in_ready  output  1  block accepts in_byte this cycle.
REQ-007 out_byte  output  BYTE_W  InvShiftRows-reordered byte, fed directly to the InvSubBytes stage.
REQ-008 out_valid  output  1  out_byte is valid.
REQ-009 out_ready  input  1  downstream accepts out_byte.
REQ-010 out_last  output  1  high with the 16th output byte of a block.

Function
REQ-011 Transfers SHALL occur on a clock edge when valid and ready are both high; no transfer otherwise.
REQ-012 Output byte index i = r + 4c SHALL equal input byte index r + 4*((c - r) mod 4) of the same block.
REQ-013 Storage SHALL be two 16-byte banks (ping-pong), each with a full flag, plus a write-bank select, a read-bank select and two 4-bit counters (wr_cnt, rd_cnt).
REQ-014 in_ready SHALL equal NOT full[wr_sel]; out_valid SHALL equal full[rd_sel]; both are registered-state decodes with no combinational path from in_valid or out_ready.
REQ-015 An accepted input byte SHALL be written at bank[wr_sel][wr_cnt], and wr_cnt SHALL increment; at wr_cnt = 15 it SHALL wrap to 0, set full[wr_sel] and toggle wr_sel.
REQ-016 out_byte SHALL be bank[rd_sel][map(rd_cnt)]; an accepted output byte SHALL increment rd_cnt; at rd_cnt = 15 it SHALL wrap to 0, clear full[rd_sel] and toggle rd_sel.
REQ-017 out_last SHALL be out_valid AND (rd_cnt = 15).
REQ-018 Latency: the first output byte SHALL be valid the cycle after the 16th input byte is accepted; sustained throughput SHALL be 1 byte/cycle with out_ready held high.
REQ-019 Simultaneous fill of one bank and drain of the other in the same cycle SHALL both take effect.
REQ-020 With both banks full, in_ready SHALL be low until a bank drains; with both banks empty, out_valid SHALL be low.
REQ-021 out_byte SHALL hold stable while out_valid is high and out_ready is low.

Reset
REQ-022 Asserting rst SHALL immediately clear both banks to 0, both full flags, both selects and both counters, and abort any partial block in progress.
REQ-023 After reset: in_ready = 1, out_valid = 0, out_last = 0, out_byte = 0.

Configuration
REQ-024 Macro ISR_FWD_MODE_EN: when defined, an extra input fwd (1 bit) SHALL be captured per bank on the first accepted byte of a block, and a bank captured with fwd = 1 SHALL be emitted with map r + 4*((c + r) mod 4), i.e. forward ShiftRows.
REQ-025 When ISR_FWD_MODE_EN is undefined, port fwd SHALL not exist and only the inverse mapping SHALL be built.

Structure
REQ-026 Package aes_isr_pkg SHALL hold constant NB = 16, the 4-bit byte-index type, and the inverse and forward index-map functions.
REQ-027 One sub-module isr_bank (16 x BYTE_W register file: one write port, one combinational read port, async clear) SHALL be instantiated twice.

Verification
REQ-028 Single block: bytes 00..0F in, out_ready = 1 -> output bytes 00 0D 0A 07 04 01 0E 0B 08 05 02 0F 0C 09 06 03; out_last only on the 03 byte.
REQ-029 Back-to-back: two blocks 00..0F then 10..1F, no gaps -> second block output is the first block's output with 0x10 added to each byte, with no idle output cycle between blocks.
REQ-030 Backpressure: out_ready = 0 while three blocks are offered -> in_ready falls after 32 accepted bytes; out_byte stays 00 while stalled.
REQ-031 Reset mid-block: rst asserted after 7 accepted bytes -> out_valid = 0 and in_ready = 1 at once; the next 16 bytes 00..0F yield the REQ-028 sequence.
REQ-032 ISR_FWD_MODE_EN with fwd = 1, bytes 00..0F -> 00 05 0A 0F 04 09 0E 03 08 0D 02 07 0C 01 06 0B.
REQ-033 Chain the block with InvSubBytes, input = FIPS-197 round-1 decryption state -> InvSubBytes output matches the published intermediate state.
